fetch_stage: RTL

Instruction-fetch stage of the pipeline: holds the program counter, computes PC+4, and selects the next PC through the existing two-input `mux` (branch target vs. sequential). It drives the instruction-memory address and captures the fetched word into the IF/ID pipeline register consumed by decode. It sits directly downstream of the next-PC `mux`, which it instantiates, and upstream of decode.

---
 rtl/pipeline_pkg.sv | 5 +
 rtl/fetch_stage_if.sv | 32 +++
 rtl/mux.sv | 12 +
 rtl/fetch_stage.sv | 80 ++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: PC increment and the all-zero bubble word.
package pipeline_pkg;
    localparam int PC_STEP = 4;
    localparam int NOP     = 0;
endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage control and IF/ID bus; stall_count exists only with FETCH_STALL_CNT_EN.
interface fetch_stage_if #(parameter int nbits = 32);
    logic             stall;
    logic             flush;
    logic             branch_taken;
    logic [nbits-1:0] branch_target;
    logic [nbits-1:0] instr_in;
    logic [nbits-1:0] imem_addr;
    logic [nbits-1:0] pc_out;
    logic [nbits-1:0] pc_plus4_out;
    logic [nbits-1:0] instr_out;
    logic             valid_out;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0]      stall_count;
`endif

    modport master (
        input  stall, flush, branch_taken, branch_target, instr_in,
        output imem_addr, pc_out, pc_plus4_out, instr_out, valid_out
`ifdef FETCH_STALL_CNT_EN
        , output stall_count
`endif
    );

    modport slave (
        output stall, flush, branch_taken, branch_target, instr_in,
        input  imem_addr, pc_out, pc_plus4_out, instr_out, valid_out
`ifdef FETCH_STALL_CNT_EN
        , input stall_count
`endif
    );
endinterface

// File: rtl/mux.sv
// Two-input word select: dec=1 picks msb, dec=0 picks lsb.
// Latency: combinational. Backpressure: none.
module mux #(
    parameter int nbits = 32
) (
    input  logic [nbits-1:0] lsb,
    input  logic [nbits-1:0] msb,
    input  logic             dec,
    output logic [nbits-1:0] out
);
    assign out = dec ? msb : lsb;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, PC+4, next-PC mux, IF/ID register. Optional FETCH_STALL_CNT_EN.
// Latency: 1 cycle from imem_addr to IF/ID; a taken branch costs one bubble.
// Backpressure: stall freezes PC and IF/ID; branch_taken overrides stall and flush.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter int               nbits    = 32,
    parameter logic [nbits-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);
    logic [nbits-1:0] pc;
    logic [nbits-1:0] pc_plus4;
    logic [nbits-1:0] next_pc;
    logic [nbits-1:0] ifid_pc;
    logic [nbits-1:0] ifid_pc_plus4;
    logic [nbits-1:0] ifid_instr;
    logic             ifid_valid;
    logic             bubble;

    assign pc_plus4 = pc + nbits'(PC_STEP);
    assign bubble   = bus.branch_taken | bus.flush;

    mux #(.nbits(nbits)) next_pc_mux (
        .lsb (pc_plus4),
        .msb (bus.branch_target),
        .dec (bus.branch_taken),
        .out (next_pc)
    );

    // A flush alone still advances the PC; only stall (without a branch) holds it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (bus.branch_taken || !bus.stall) begin
            pc <= next_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ifid_pc       <= nbits'(NOP);
            ifid_pc_plus4 <= nbits'(NOP);
            ifid_instr    <= nbits'(NOP);
            ifid_valid    <= 1'b0;
        end else if (bubble) begin
            ifid_pc       <= nbits'(NOP);
            ifid_pc_plus4 <= nbits'(NOP);
            ifid_instr    <= nbits'(NOP);
            ifid_valid    <= 1'b0;
        end else if (!bus.stall) begin
            ifid_pc       <= pc;
            ifid_pc_plus4 <= pc_plus4;
            ifid_instr    <= bus.instr_in;
            ifid_valid    <= 1'b1;
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (bus.stall && !bus.branch_taken && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign bus.stall_count = stall_cnt;
`endif

    assign bus.imem_addr    = pc;
    assign bus.pc_out       = ifid_pc;
    assign bus.pc_plus4_out = ifid_pc_plus4;
    assign bus.instr_out    = ifid_instr;
    assign bus.valid_out    = ifid_valid;
endmodule
